lib_voq_requester: RTL and testbench

LIB_VOQ_REQUESTER -- requirements
Module: lib_voq_requester

---
 rtl/lib_voq_requester.sv | 104 ++++++++++
 tb/tb_lib_voq_requester.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lib_voq_requester.sv
// Virtual output queues: M FIFOs of DEPTH x WIDTH, non-empty VOQs request the allocator, one pop per grant.
// Dequeued data appears 1 cycle after the grant; o_full gives upstream flow control, enqueue to a full VOQ drops and flags o_error.
module lib_voq_requester #(
  parameter int M     = 4,
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_data_val,
  input  logic [$clog2(M)-1:0] i_data_dest,
  output logic [0:M-1]         o_full,
  output logic [0:M-1]         o_request,
  input  logic [0:M-1]         i_grant,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_data_val,
  output logic [$clog2(M)-1:0] o_data_dest,
  output logic                 o_error
);

  localparam int DW = $clog2(M);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem    [M][DEPTH];
  logic [PW-1:0]    rd_ptr [M];
  logic [PW-1:0]    wr_ptr [M];
  logic [CW-1:0]    cnt    [M];

  logic [0:M-1]  push;
  logic [0:M-1]  pop;
  logic          pop_vld;
  logic [DW-1:0] pop_idx;
  logic          dest_ok;
  logic          err_set;

  always_comb begin
    for (int j = 0; j < M; j++) begin
      o_request[j] = (cnt[j] != '0);
      o_full[j]    = (cnt[j] == CW'(DEPTH));
    end
  end

  assign dest_ok = ({1'b0, i_data_dest} < (DW+1)'(M));

  always_comb begin
    push    = '0;
    pop     = '0;
    pop_vld = 1'b0;
    pop_idx = '0;
    // Descending scan so the lowest-index granted non-empty VOQ wins.
    for (int j = M - 1; j >= 0; j--) begin
      if (i_grant[j] && o_request[j]) begin
        pop_vld = 1'b1;
        pop_idx = DW'(j);
      end
    end
    for (int j = 0; j < M; j++) begin
      pop[j] = pop_vld && (pop_idx == DW'(j));
    end
    if (i_data_val && dest_ok && !o_full[i_data_dest]) begin
      push[i_data_dest] = 1'b1;
    end
    err_set = (i_data_val && (!dest_ok || o_full[i_data_dest]))
            || (|(i_grant & ~o_request))
            || ($countones(i_grant) > 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < M; j++) begin
        rd_ptr[j] <= '0;
        wr_ptr[j] <= '0;
        cnt[j]    <= '0;
      end
      o_data_val  <= 1'b0;
      o_data      <= '0;
      o_data_dest <= '0;
      o_error     <= 1'b0;
    end else begin
      for (int j = 0; j < M; j++) begin
        if (push[j]) wr_ptr[j] <= wr_ptr[j] + 1'b1;
        if (pop[j])  rd_ptr[j] <= rd_ptr[j] + 1'b1;
        if (push[j] && !pop[j])      cnt[j] <= cnt[j] + 1'b1;
        else if (!push[j] && pop[j]) cnt[j] <= cnt[j] - 1'b1;
      end
      o_data_val <= pop_vld;
      if (pop_vld) begin
        o_data      <= mem[pop_idx][rd_ptr[pop_idx]];
        o_data_dest <= pop_idx;
      end
      if (err_set) o_error <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int j = 0; j < M; j++) begin
      if (push[j]) mem[j][wr_ptr[j]] <= i_data;
    end
  end

endmodule

// File: tb/tb_lib_voq_requester.sv
// Scoreboard bench for lib_voq_requester: a queue model predicts dequeued packets, the monitor compares them.
module tb_lib_voq_requester;

  localparam int M     = 4;
  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] i_data = '0;
  logic             i_data_val = 1'b0;
  logic [1:0]       i_data_dest = '0;
  logic [0:M-1]     o_full;
  logic [0:M-1]     o_request;
  logic [0:M-1]     i_grant = '0;
  logic [WIDTH-1:0] o_data;
  logic             o_data_val;
  logic [1:0]       o_data_dest;
  logic             o_error;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] mq [M][$];
  logic [WIDTH-1:0] exp_data [$];
  logic [1:0]       exp_dest [$];

  lib_voq_requester #(.M(M), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .i_data(i_data), .i_data_val(i_data_val),
    .i_data_dest(i_data_dest), .o_full(o_full), .o_request(o_request),
    .i_grant(i_grant), .o_data(o_data), .o_data_val(o_data_val),
    .o_data_dest(o_data_dest), .o_error(o_error)
  );

  always #5 clk = ~clk;

  // Output monitor: every o_data_val pulse must match the next predicted packet.
  always @(negedge clk) begin
    if (!reset && o_data_val) begin
      checks++;
      if (exp_data.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: got data=%h dest=%0d, no packet expected", o_data, o_data_dest);
      end else begin
        logic [WIDTH-1:0] ed;
        logic [1:0] edst;
        ed = exp_data.pop_front();
        edst = exp_dest.pop_front();
        if (o_data !== ed || o_data_dest !== edst) begin
          failures++;
          $display("FAIL scoreboard: got data=%h dest=%0d, expected data=%h dest=%0d", o_data, o_data_dest, ed, edst);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of stimulus and update the reference queues as the edge is taken.
  task automatic step(input logic v, input logic [1:0] d, input logic [WIDTH-1:0] dat,
                      input logic [0:M-1] g);
    int pj;
    bit full_pre;
    logic [WIDTH-1:0] popped;
    i_data_val = v; i_data_dest = d; i_data = dat; i_grant = g;
    full_pre = (mq[d].size() == DEPTH);
    pj = -1;
    for (int j = M - 1; j >= 0; j--) if (g[j] && mq[j].size() != 0) pj = j;
    @(posedge clk);
    if (pj >= 0) begin
      popped = mq[pj].pop_front();
      exp_data.push_back(popped);
      exp_dest.push_back(2'(pj));
    end
    if (v && !full_pre) mq[d].push_back(dat);
    #1;
    i_data_val = 1'b0; i_grant = '0;
  endtask

  task automatic clear_model();
    for (int j = 0; j < M; j++) mq[j].delete();
    exp_data.delete();
    exp_dest.delete();
  endtask

  task automatic apply_reset();
    #2 reset = 1'b1;
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain_check(input string name);
    step(1'b0, 2'd0, '0, '0);
    step(1'b0, 2'd0, '0, '0);
    checks++;
    if (exp_data.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d predicted packets never appeared, expected 0", name, exp_data.size());
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (o_request !== 4'b0000 || o_full !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: request=%b full=%b, expected 0000 0000", o_request, o_full);
    end
    checks++;
    if (o_data_val !== 1'b0 || o_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: data_val=%b error=%b, expected 0 0", o_data_val, o_error);
    end
    checks++;
    if (o_data !== '0 || o_data_dest !== 2'd0) begin
      failures++;
      $display("FAIL reset_data: data=%h dest=%0d, expected 0 0", o_data, o_data_dest);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    step(1'b1, 2'd2, 32'hA1, '0);
    checks++;
    if (o_request !== 4'b0010) begin
      failures++;
      $display("FAIL basic_request: request=%b, expected 0010", o_request);
    end
    step(1'b0, 2'd0, '0, 4'b0010);
    checks++;
    if (o_data_val !== 1'b1 || o_data !== 32'hA1 || o_data_dest !== 2'd2) begin
      failures++;
      $display("FAIL basic_latency: val=%b data=%h dest=%0d, expected 1 a1 2", o_data_val, o_data, o_data_dest);
    end
    checks++;
    if (o_request !== 4'b0000 || o_error !== 1'b0) begin
      failures++;
      $display("FAIL basic_after_pop: request=%b error=%b, expected 0000 0", o_request, o_error);
    end
    drain_check("basic");
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 2'd1, 32'(i), '0);
    checks++;
    if (o_full !== 4'b0100 || o_error !== 1'b0) begin
      failures++;
      $display("FAIL full_flag: full=%b error=%b, expected 0100 0", o_full, o_error);
    end
    step(1'b1, 2'd1, 32'h99, '0);
    checks++;
    if (o_error !== 1'b1 || o_full !== 4'b0100) begin
      failures++;
      $display("FAIL full_drop: error=%b full=%b, expected 1 0100", o_error, o_full);
    end
    for (int i = 0; i < DEPTH; i++) step(1'b0, 2'd0, '0, 4'b0100);
    drain_check("full");
    checks++;
    if (o_request !== 4'b0000) begin
      failures++;
      $display("FAIL full_empty: request=%b, expected 0000", o_request);
    end
  endtask

  task automatic test_full_pop_push();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 2'd3, 32'h300 + 32'(i), '0);
    step(1'b1, 2'd3, 32'hDEAD, 4'b0001);
    checks++;
    if (o_error !== 1'b1 || o_full !== 4'b0000 || o_request !== 4'b0001) begin
      failures++;
      $display("FAIL full_pop_push: error=%b full=%b req=%b, expected 1 0000 0001", o_error, o_full, o_request);
    end
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 2'd0, '0, 4'b0001);
    drain_check("full_pop_push");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 32'h1000 + 32'(i), '0);
    for (int i = 0; i < 20; i++) step(1'b1, 2'd0, 32'h2000 + 32'(i), 4'b1000);
    checks++;
    if (o_request !== 4'b1000 || o_full !== 4'b0000 || o_error !== 1'b0) begin
      failures++;
      $display("FAIL b2b_state: req=%b full=%b error=%b, expected 1000 0000 0", o_request, o_full, o_error);
    end
    for (int i = 0; i < 2; i++) step(1'b0, 2'd0, '0, 4'b1000);
    checks++;
    if (o_request !== 4'b1000) begin
      failures++;
      $display("FAIL b2b_count: req=%b after 2 pops, expected 1000 (one entry left)", o_request);
    end
    step(1'b0, 2'd0, '0, 4'b1000);
    checks++;
    if (o_request !== 4'b0000) begin
      failures++;
      $display("FAIL b2b_empty: req=%b after 3 pops, expected 0000", o_request);
    end
    drain_check("b2b");
  endtask

  task automatic test_multihot();
    apply_reset();
    step(1'b1, 2'd1, 32'hB1, '0);
    step(1'b1, 2'd2, 32'hB2, '0);
    step(1'b0, 2'd0, '0, 4'b0110);
    checks++;
    if (o_error !== 1'b1 || o_request !== 4'b0010 || o_data_dest !== 2'd1) begin
      failures++;
      $display("FAIL multihot: error=%b req=%b dest=%0d, expected 1 0010 1", o_error, o_request, o_data_dest);
    end
    step(1'b0, 2'd0, '0, 4'b0010);
    drain_check("multihot");
  endtask

  task automatic test_grant_empty();
    apply_reset();
    step(1'b1, 2'd0, 32'hC0, '0);
    step(1'b0, 2'd0, '0, 4'b0001);
    checks++;
    if (o_data_val !== 1'b0 || o_error !== 1'b1 || o_request !== 4'b1000) begin
      failures++;
      $display("FAIL grant_empty: val=%b error=%b req=%b, expected 0 1 1000", o_data_val, o_error, o_request);
    end
    step(1'b0, 2'd0, '0, 4'b1000);
    drain_check("grant_empty");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 2'(i % 2), 32'h500 + 32'(i), '0);
    step(1'b1, 2'd3, 32'h5FF, 4'b1001);
    #1 reset = 1'b1;
    clear_model();
    #1;
    checks++;
    if (o_request !== 4'b0000 || o_full !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_flags: req=%b full=%b, expected 0000 0000", o_request, o_full);
    end
    checks++;
    if (o_data_val !== 1'b0 || o_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs: val=%b error=%b, expected 0 0", o_data_val, o_error);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 2'd0, '0, 4'b1111);
    checks++;
    if (o_error !== 1'b1 || o_request !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_after: error=%b req=%b, expected 1 0000", o_error, o_request);
    end
    drain_check("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_full_pop_push();
    test_back_to_back();
    test_multihot();
    test_grant_empty();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
